// File: rtl/multi_sphere_renderer.sv
// Multi-ball bouncing renderer: a shared motion FSM steps every ball once per top+2 cycles,
// and a 2-stage shading pipeline max-blends per-ball glow levels into a 4-bit intensity.
module multi_sphere_renderer #(
    parameter int          NBALLS    = 4,
    parameter int          COORD_W   = 7,
    parameter int          H_MAX     = 80,
    parameter int          V_MAX     = 60,
    parameter int          MARGIN    = 10,
    parameter int          RADIUS_SQ = 32,
    parameter int          GLOW      = 128,
    parameter int          SPD_W     = 21,
    parameter logic [15:0] START_DIR = 16'h00A5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [COORD_W-1:0]          pix_h,
    input  logic [COORD_W-1:0]          pix_v,
    input  logic                        pix_valid,
    input  logic [SPD_W-1:0]            top,
    input  logic [NBALLS-1:0]           ball_en,
    output logic [3:0]                  color,
    output logic                        color_valid,
    output logic [NBALLS*COORD_W-1:0]   ball_h,
    output logic [NBALLS*COORD_W-1:0]   ball_v
);

    localparam int D2_W = 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] LO_C   = COORD_W'(MARGIN);
    localparam logic [COORD_W-1:0] H_HI_C = COORD_W'(H_MAX - MARGIN);
    localparam logic [COORD_W-1:0] V_HI_C = COORD_W'(V_MAX - MARGIN);
    localparam logic [D2_W-1:0]    CORE_C = D2_W'(RADIUS_SQ + 16);
    localparam logic [D2_W-1:0]    GLOW_C = D2_W'(RADIUS_SQ + GLOW);

    typedef enum logic {COUNT, MOVE} phase_t;

    phase_t           phase_q, phase_d;
    logic [SPD_W-1:0] spd_cnt_q, spd_cnt_d;
    logic             do_move;
    logic             bounce_chk;
    logic [3:0]       lvl [NBALLS];
    logic [3:0]       max_lvl;
    logic [3:0]       color_q;
    logic             valid1_q, valid2_q;

    // A top lowered below the running count forces an immediate step.
    always_comb begin
        phase_d    = phase_q;
        spd_cnt_d  = spd_cnt_q;
        do_move    = 1'b0;
        bounce_chk = 1'b0;
        if (phase_q == MOVE || spd_cnt_q > top) begin
            do_move   = 1'b1;
            spd_cnt_d = '0;
            phase_d   = COUNT;
        end else begin
            spd_cnt_d = spd_cnt_q + SPD_W'(1);
            if (spd_cnt_q == top) begin
                bounce_chk = 1'b1;
                phase_d    = MOVE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= COUNT;
            spd_cnt_q <= '0;
        end else begin
            phase_q   <= phase_d;
            spd_cnt_q <= spd_cnt_d;
        end
    end

    function automatic logic [3:0] level_of(input logic [D2_W-1:0] d2);
        logic [D2_W-1:0] ramp;
        ramp = (d2 - CORE_C) >> 3;
        if (d2 < CORE_C)
            level_of = 4'd15;
        else if (d2 < GLOW_C && ramp < D2_W'(16))
            level_of = 4'd15 - ramp[3:0];
        else
            level_of = 4'd0;
    endfunction

    for (genvar gi = 0; gi < NBALLS; gi++) begin : g_ball
        logic [COORD_W-1:0]    h_q, h_d, v_q, v_d;
        logic                  dir_h_q, dir_h_d, dir_v_q, dir_v_d;
        logic signed [D2_W-1:0] dh, dv;
        logic [D2_W-1:0]       d2_d, d2_q;

        always_comb begin
            h_d     = h_q;
            v_d     = v_q;
            dir_h_d = dir_h_q;
            dir_v_d = dir_v_q;
            if (do_move) begin
                h_d = dir_h_q ? h_q + COORD_W'(1) : h_q - COORD_W'(1);
                v_d = dir_v_q ? v_q + COORD_W'(1) : v_q - COORD_W'(1);
            end
            if (bounce_chk) begin
                if (h_q < LO_C)   dir_h_d = 1'b1;
                if (h_q > H_HI_C) dir_h_d = 1'b0;
                if (v_q < LO_C)   dir_v_d = 1'b1;
                if (v_q > V_HI_C) dir_v_d = 1'b0;
            end
        end

        // Differences are formed at full square width so the products cannot overflow.
        assign dh   = $signed({{(COORD_W+1){1'b0}}, pix_h}) - $signed({{(COORD_W+1){1'b0}}, h_q});
        assign dv   = $signed({{(COORD_W+1){1'b0}}, pix_v}) - $signed({{(COORD_W+1){1'b0}}, v_q});
        assign d2_d = $unsigned(dh * dh) + $unsigned(dv * dv);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                h_q     <= COORD_W'(16 + 12 * gi);
                v_q     <= COORD_W'(32);
                dir_h_q <= START_DIR[2*gi+1];
                dir_v_q <= START_DIR[2*gi];
                d2_q    <= '0;
            end else begin
                h_q     <= h_d;
                v_q     <= v_d;
                dir_h_q <= dir_h_d;
                dir_v_q <= dir_v_d;
                d2_q    <= d2_d;
            end
        end

        assign lvl[gi] = ball_en[gi] ? level_of(d2_q) : 4'd0;
        assign ball_h[gi*COORD_W +: COORD_W] = h_q;
        assign ball_v[gi*COORD_W +: COORD_W] = v_q;
    end

    always_comb begin
        max_lvl = '0;
        for (int i = 0; i < NBALLS; i++) begin
            if (lvl[i] > max_lvl) max_lvl = lvl[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_q  <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            color_q  <= max_lvl;
            valid1_q <= pix_valid;
            valid2_q <= valid1_q;
        end
    end

    assign color       = color_q;
    assign color_valid = valid2_q;

endmodule

// File: tb/tb_multi_sphere_renderer.sv
// Scoreboard bench for multi_sphere_renderer: stimulus pushes expected colours and
// state checks tagged with a cycle; one negedge monitor pops and compares them.
module tb_multi_sphere_renderer;
    localparam int NB = 4;
    localparam int CW = 7;
    localparam int SW = 21;

    logic             clk = 1'b0;
    logic             reset;
    logic [CW-1:0]    pix_h, pix_v;
    logic             pix_valid;
    logic [SW-1:0]    top;
    logic [NB-1:0]    ball_en;
    logic [3:0]       color;
    logic             color_valid;
    logic [NB*CW-1:0] ball_h, ball_v;

    always #5 clk = ~clk;

    multi_sphere_renderer dut (
        .clk(clk), .reset(reset), .pix_h(pix_h), .pix_v(pix_v), .pix_valid(pix_valid),
        .top(top), .ball_en(ball_en), .color(color), .color_valid(color_valid),
        .ball_h(ball_h), .ball_v(ball_v)
    );

    typedef struct { int col; int cyc; string name; } col_t;
    typedef struct { int cyc; int sel; int val; string name; } st_t;
    typedef struct packed { logic [3:0] en; logic [6:0] h; logic [6:0] v; logic [3:0] exp; } vec_t;

    localparam int SEL_COLOR = 0;
    localparam int SEL_VALID = 1;
    localparam int SEL_H     = 10;
    localparam int SEL_V     = 20;

    col_t col_q[$];
    st_t  st_q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int observe(input int sel);
        if (sel == SEL_COLOR) return int'(color);
        if (sel == SEL_VALID) return int'(color_valid);
        if (sel < SEL_V)      return int'(ball_h[(sel-SEL_H)*CW +: CW]);
        return int'(ball_v[(sel-SEL_V)*CW +: CW]);
    endfunction

    // Single monitor owns all counters.
    always @(negedge clk) begin
        st_t  s;
        col_t c;
        int   act;
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s   = st_q.pop_front();
            act = observe(s.sel);
            compared++;
            if (act != s.val || s.cyc != cyc) begin
                mismatched++;
                $display("FAIL %s: got %0d at cycle %0d, expected %0d at cycle %0d", s.name, act, cyc, s.val, s.cyc);
            end else
                $display("PASS %s: %0d at cycle %0d", s.name, act, cyc);
        end
        if (!reset && color_valid) begin
            compared++;
            if (col_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid: color=%0d color_valid=1 at cycle %0d, expected no output", color, cyc);
            end else begin
                c = col_q.pop_front();
                if (int'(color) != c.col || cyc != c.cyc) begin
                    mismatched++;
                    $display("FAIL %s: color=%0d at cycle %0d, expected %0d at cycle %0d", c.name, color, cyc, c.col, c.cyc);
                end else
                    $display("PASS %s: color=%0d at cycle %0d", c.name, color, cyc);
            end
        end
        if (done) begin
            compared++;
            if (col_q.size() != 0 || st_q.size() != 0) begin
                mismatched++;
                $display("FAIL drain: %0d colours and %0d state checks still pending, expected 0 and 0", col_q.size(), st_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input int sel, input int val, input string nm);
        st_t s;
        s.cyc = cyc + d; s.sel = sel; s.val = val; s.name = nm;
        st_q.push_back(s);
    endtask

    task automatic send(input logic [6:0] h, input logic [6:0] v, input int expc, input string nm);
        col_t c;
        pix_h = h; pix_v = v; pix_valid = 1'b1;
        c.col = expc; c.cyc = cyc + 2; c.name = nm;
        col_q.push_back(c);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [SW-1:0] t);
        reset = 1'b1; pix_valid = 1'b0; top = t;
        tick(); tick();
        reset = 1'b0;
    endtask

    vec_t vecs [15] = '{
        '{4'b0001, 7'd16, 7'd32, 4'd15},
        '{4'b0001, 7'd23, 7'd32, 4'd15},
        '{4'b0001, 7'd27, 7'd32, 4'd6},
        '{4'b0001, 7'd30, 7'd32, 4'd0},
        '{4'b0001, 7'd28, 7'd35, 4'd2},
        '{4'b0001, 7'd28, 7'd36, 4'd0},
        '{4'b0001, 7'd9,  7'd29, 4'd14},
        '{4'b0001, 7'd4,  7'd32, 4'd3},
        '{4'b0011, 7'd22, 7'd32, 4'd15},
        '{4'b0011, 7'd21, 7'd32, 4'd15},
        '{4'b0010, 7'd16, 7'd32, 4'd3},
        '{4'b0000, 7'd16, 7'd32, 4'd0},
        '{4'b1000, 7'd52, 7'd40, 4'd13},
        '{4'b0100, 7'd40, 7'd20, 4'd3},
        '{4'b1111, 7'd45, 7'd38, 4'd14}
    };
    int bounce_h0 [10] = '{16, 15, 14, 13, 12, 11, 10, 9, 10, 11};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pix_h = '0; pix_v = '0; pix_valid = 1'b0; top = '0; ball_en = '0;
        tick(); tick();
        chk(0, SEL_COLOR, 0, "rst_color");
        chk(0, SEL_VALID, 0, "rst_valid");
        for (int k = 0; k < NB; k++) begin
            chk(0, SEL_H + k, 16 + 12 * k, $sformatf("rst_h%0d", k));
            chk(0, SEL_V + k, 32, $sformatf("rst_v%0d", k));
        end

        // Reset asserted while the FSM sits in MOVE with top = 0.
        top = '0; ball_en = 4'hF; pix_h = 7'd16; pix_v = 7'd32;
        reset = 1'b0;
        tick(); tick();
        chk(0, SEL_H + 0, 15, "pre_rst_h0");
        chk(0, SEL_COLOR, 15, "pre_rst_color");
        tick();
        #1 reset = 1'b1;
        chk(0, SEL_COLOR, 0, "midmove_color");
        chk(0, SEL_VALID, 0, "midmove_valid");
        chk(0, SEL_H + 0, 16, "midmove_h0");
        chk(0, SEL_V + 0, 32, "midmove_v0");
        chk(0, SEL_H + 3, 52, "midmove_h3");
        chk(0, SEL_V + 3, 32, "midmove_v3");
        tick();

        // Shading vectors at reset positions; balls hold still for 101 cycles.
        do_reset(21'd100);
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || vecs[i].en != vecs[i-1].en) begin
                pix_valid = 1'b0; tick(); tick();
                ball_en = vecs[i].en;
            end
            send(vecs[i].h, vecs[i].v, int'(vecs[i].exp),
                 $sformatf("shade%0d_(%0d,%0d)", i, vecs[i].h, vecs[i].v));
        end
        tick(); tick(); tick();

        // Bounce at the left edge, top = 0.
        do_reset(21'd0);
        ball_en = '0;
        for (int e = 1; e <= 18; e++) begin
            chk(e, SEL_H + 0, bounce_h0[e/2], $sformatf("bounce_h0_e%0d", e));
            chk(e, SEL_H + 3, 52 + e / 2, $sformatf("bounce_h3_e%0d", e));
        end
        repeat (19) tick();

        // Lowering top mid-count forces an immediate step.
        do_reset(21'd50);
        repeat (40) tick();
        top = 21'd10;
        chk(0, SEL_H + 0, 16, "midcnt_h0_before");
        chk(1, SEL_H + 0, 15, "midcnt_h0");
        chk(1, SEL_V + 0, 33, "midcnt_v0");
        chk(1, SEL_H + 1, 27, "midcnt_h1");
        chk(1, SEL_V + 1, 33, "midcnt_v1");
        chk(1, SEL_H + 2, 41, "midcnt_h2");
        chk(1, SEL_V + 2, 31, "midcnt_v2");
        chk(1, SEL_H + 3, 53, "midcnt_h3");
        chk(1, SEL_V + 3, 31, "midcnt_v3");
        chk(12, SEL_H + 0, 15, "midcnt_h0_hold");
        chk(13, SEL_H + 0, 14, "midcnt_h0_next");
        repeat (15) tick();

        done = 1'b1;
    end
endmodule
